// File: rtl/wb_stage.sv
// Registered writeback stage for the rysy core: source select, load
// alignment/extension, PC+4 delay line and late-load wait FSM.
module wb_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned PC_DLY  = 1,
    parameter int unsigned OFF_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [2:0]         rd_sel,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]    imm,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    alu_out,
    input  logic [XLEN-1:0]    csr_rdata,
    input  logic [XLEN-1:0]    mem_rdata,
    input  logic               mem_rvalid,
    input  logic [1:0]         ld_size,
    input  logic               ld_unsigned,
    input  logic [OFF_W-1:0]   byte_off,
    output logic               rd_we,
    output logic [RADDR_W-1:0] rd_waddr,
    output logic [XLEN-1:0]    rd_wdata,
    output logic               busy
);

    localparam logic [2:0] SEL_IMM  = 3'd0;
    localparam logic [2:0] SEL_PCP4 = 3'd1;
    localparam logic [2:0] SEL_ALU  = 3'd2;
    localparam logic [2:0] SEL_MEM  = 3'd3;
    localparam logic [2:0] SEL_CSR  = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic                 we_nxt;
    logic [RADDR_W-1:0]   waddr_nxt;
    logic [XLEN-1:0]      wdata_nxt;
    logic                 cap_en;
    logic [RADDR_W-1:0]   cap_addr;
    logic [1:0]           cap_size;
    logic                 cap_unsigned;
    logic [OFF_W-1:0]     cap_off;
    logic [XLEN-1:0]      pcp4_src;

    // Align the addressed lane to bit 0, then sign- or zero-extend it.
    function automatic logic [XLEN-1:0] fmt_load(
        input logic [XLEN-1:0]  raw,
        input logic [1:0]       size,
        input logic             uns,
        input logic [OFF_W-1:0] off
    );
        logic [OFF_W-1:0] eff;
        logic [XLEN-1:0]  lane;
        logic [XLEN-1:0]  mask;
        logic             sgn;
        case (size)
            SZ_BYTE: eff = off;
            SZ_HALF: eff = off & ~OFF_W'(1);
            SZ_WORD: eff = (XLEN == 64) ? {off[OFF_W-1], {(OFF_W-1){1'b0}}} : '0;
            default: eff = '0;
        endcase
        lane = raw >> {eff, 3'b000};
        case (size)
            SZ_BYTE: begin mask = XLEN'(8'hFF);         sgn = lane[7];  end
            SZ_HALF: begin mask = XLEN'(16'hFFFF);      sgn = lane[15]; end
            SZ_WORD: begin mask = XLEN'(32'hFFFF_FFFF); sgn = lane[31]; end
            default: begin
                // A double access on a 32-bit core degenerates to a word.
                mask = '1;
                sgn  = lane[XLEN-1];
            end
        endcase
        return (lane & mask) | ((!uns && sgn) ? ~mask : '0);
    endfunction

    // PC+4 delay line: frozen while stalled, bypassed when zero-depth.
    generate
        if (PC_DLY == 0) begin : g_no_dly
            assign pcp4_src = pc;
        end else begin : g_dly
            logic [XLEN-1:0] pc_q [PC_DLY];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(PC_DLY); i++) pc_q[i] <= '0;
                end else if (!stall) begin
                    pc_q[0] <= pc;
                    for (int i = 1; i < int'(PC_DLY); i++) pc_q[i] <= pc_q[i-1];
                end
            end
            assign pcp4_src = pc_q[PC_DLY-1];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, completion decode and busy.
    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        waddr_nxt = rd_waddr;
        wdata_nxt = rd_wdata;
        cap_en    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && !stall && !flush) begin
                    case (rd_sel)
                        SEL_IMM, SEL_PCP4, SEL_ALU, SEL_CSR: begin
                            we_nxt    = (rd_addr != '0);
                            waddr_nxt = rd_addr;
                            case (rd_sel)
                                SEL_IMM:  wdata_nxt = imm;
                                SEL_PCP4: wdata_nxt = pcp4_src;
                                SEL_ALU:  wdata_nxt = alu_out;
                                default:  wdata_nxt = csr_rdata;
                            endcase
                        end
                        SEL_MEM: begin
                            if (mem_rvalid) begin
                                we_nxt    = (rd_addr != '0);
                                waddr_nxt = rd_addr;
                                wdata_nxt = fmt_load(mem_rdata, ld_size, ld_unsigned, byte_off);
                            end else begin
                                cap_en    = 1'b1;
                                state_nxt = WAIT_MEM;
                            end
                        end
                        default: ; // reserved selects are consumed silently
                    endcase
                end
            end
            WAIT_MEM: begin
                busy = !mem_rvalid;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (mem_rvalid) begin
                    we_nxt    = (cap_addr != '0);
                    waddr_nxt = cap_addr;
                    wdata_nxt = fmt_load(mem_rdata, cap_size, cap_unsigned, cap_off);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load context captured when the read data is late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr     <= '0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
            cap_off      <= '0;
        end else if (cap_en) begin
            cap_addr     <= rd_addr;
            cap_size     <= ld_size;
            cap_unsigned <= ld_unsigned;
            cap_off      <= byte_off;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_we    <= 1'b0;
            rd_waddr <= '0;
            rd_wdata <= '0;
        end else begin
            rd_we    <= we_nxt;
            rd_waddr <= waddr_nxt;
            rd_wdata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares every rd_we pulse.
module tb_wb_stage;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned PC_DLY  = 1;
    localparam int unsigned OFF_W   = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stall, flush, in_valid;
    logic [2:0]         rd_sel;
    logic [RADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]    imm, pc, alu_out, csr_rdata, mem_rdata;
    logic               mem_rvalid;
    logic [1:0]         ld_size;
    logic               ld_unsigned;
    logic [OFF_W-1:0]   byte_off;
    logic               rd_we;
    logic [RADDR_W-1:0] rd_waddr;
    logic [XLEN-1:0]    rd_wdata;
    logic               busy;

    typedef struct packed {
        logic [RADDR_W-1:0] addr;
        logic [XLEN-1:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    wb_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .PC_DLY(PC_DLY), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .imm(imm), .pc(pc), .alu_out(alu_out), .csr_rdata(csr_rdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .ld_size(ld_size),
        .ld_unsigned(ld_unsigned), .byte_off(byte_off),
        .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [RADDR_W-1:0] a, input logic [XLEN-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic issue(input logic [2:0] sel, input logic [RADDR_W-1:0] a);
        in_valid = 1'b1;
        rd_sel   = sel;
        rd_addr  = a;
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && rd_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, rd_waddr, rd_wdata}, 64'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write", {27'd0, rd_waddr, rd_wdata}, {27'd0, w.addr, w.data});
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        rd_sel = 3'd0; rd_addr = '0; imm = '0; pc = '0; alu_out = '0;
        csr_rdata = '0; mem_rdata = '0; mem_rvalid = 1'b0;
        ld_size = 2'd0; ld_unsigned = 1'b0; byte_off = '0;

        // Reset state
        #12;
        chk("reset_we", 64'(rd_we), 64'd0);
        chk("reset_waddr", 64'(rd_waddr), 64'd0);
        chk("reset_wdata", 64'(rd_wdata), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ALU writeback, latency 1, single-cycle strobe
        issue(3'd2, 5'd5); alu_out = 32'h0000_1234;
        expect_wr(5'd5, 32'h0000_1234);
        tick(); in_valid = 1'b0;
        tick();
        chk("alu_we_drop", 64'(rd_we), 64'd0);

        // PC+4 through one-stage delay line
        pc = 32'h100; tick();
        pc = 32'h104; issue(3'd1, 5'd6);
        expect_wr(5'd6, 32'h100);
        tick(); in_valid = 1'b0;

        // Delay line holds while stalled
        pc = 32'h200; tick();
        stall = 1'b1; pc = 32'h204; tick(); tick();
        stall = 1'b0; pc = 32'h208; issue(3'd1, 5'd7);
        expect_wr(5'd7, 32'h200);
        tick(); in_valid = 1'b0;

        // Late signed byte load; context captured, inputs then disturbed
        issue(3'd3, 5'd8); ld_size = 2'd0; ld_unsigned = 1'b0; byte_off = 2'd2;
        mem_rdata = 32'h0080_0000; mem_rvalid = 1'b0;
        tick(); in_valid = 1'b0; ld_size = 2'd2; byte_off = 2'd0; ld_unsigned = 1'b1;
        chk("busy_c1", 64'(busy), 64'd1); tick();
        chk("busy_c2", 64'(busy), 64'd1); tick();
        chk("busy_c3", 64'(busy), 64'd1);
        mem_rvalid = 1'b1; #1;
        chk("busy_rvalid", 64'(busy), 64'd0);
        expect_wr(5'd8, 32'hFFFF_FF80);
        tick(); mem_rvalid = 1'b0;

        // Late unsigned byte load, completes despite stall
        issue(3'd3, 5'd9); ld_size = 2'd0; ld_unsigned = 1'b1; byte_off = 2'd2;
        tick(); in_valid = 1'b0; stall = 1'b1;
        chk("busy_uns", 64'(busy), 64'd1);
        mem_rvalid = 1'b1;
        expect_wr(5'd9, 32'h0000_0080);
        tick(); mem_rvalid = 1'b0; stall = 1'b0;

        // Half load, data ready in accept cycle, offset bit 0 ignored
        issue(3'd3, 5'd10); ld_size = 2'd1; ld_unsigned = 1'b0; byte_off = 2'd3;
        mem_rdata = 32'h8001_0000; mem_rvalid = 1'b1; #1;
        chk("half_busy_accept", 64'(busy), 64'd0);
        expect_wr(5'd10, 32'hFFFF_8001);
        tick(); in_valid = 1'b0; mem_rvalid = 1'b0;
        chk("half_busy_after", 64'(busy), 64'd0);

        // Word and double (treated as word) loads ignore the offset
        issue(3'd3, 5'd11); ld_size = 2'd2; ld_unsigned = 1'b0; byte_off = 2'd1;
        mem_rdata = 32'hDEAD_BEEF; mem_rvalid = 1'b1;
        expect_wr(5'd11, 32'hDEAD_BEEF);
        tick();
        issue(3'd3, 5'd12); ld_size = 2'd3; byte_off = 2'd3; mem_rdata = 32'h8765_4321;
        expect_wr(5'd12, 32'h8765_4321);
        tick();
        // Unsigned byte at top lane, then CSR and IMM back to back
        issue(3'd3, 5'd13); ld_size = 2'd0; ld_unsigned = 1'b1; byte_off = 2'd3;
        mem_rdata = 32'hF100_0000;
        expect_wr(5'd13, 32'h0000_00F1);
        tick(); mem_rvalid = 1'b0;
        issue(3'd4, 5'd14); csr_rdata = 32'hCAFE_F00D;
        expect_wr(5'd14, 32'hCAFE_F00D);
        tick();
        issue(3'd0, 5'd15); imm = 32'h55;
        expect_wr(5'd15, 32'h55);
        tick(); in_valid = 1'b0;

        // x0 destination: data updates, no strobe
        issue(3'd0, 5'd0); imm = 32'd7;
        tick(); in_valid = 1'b0;
        chk("x0_we", 64'(rd_we), 64'd0);
        chk("x0_wdata", 64'(rd_wdata), 64'd7);
        chk("x0_waddr", 64'(rd_waddr), 64'd0);

        // Reserved select: consumed, outputs unchanged
        issue(3'd6, 5'd3); imm = 32'd9; alu_out = 32'h99;
        tick(); in_valid = 1'b0;
        chk("rsv_we", 64'(rd_we), 64'd0);
        chk("rsv_wdata", 64'(rd_wdata), 64'd7);
        chk("rsv_waddr", 64'(rd_waddr), 64'd0);

        // Flush beats simultaneous rvalid in WAIT_MEM
        issue(3'd3, 5'd16); ld_size = 2'd2; mem_rvalid = 1'b0;
        tick(); in_valid = 1'b0;
        chk("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1; mem_rvalid = 1'b1;
        tick(); flush = 1'b0; mem_rvalid = 1'b0;
        chk("flush_we", 64'(rd_we), 64'd0);
        chk("flush_idle", 64'(busy), 64'd0);
        issue(3'd2, 5'd17); alu_out = 32'hA5A5_0001;
        expect_wr(5'd17, 32'hA5A5_0001);
        tick(); in_valid = 1'b0;

        // Reset mid-WAIT_MEM drops the pending load
        issue(3'd3, 5'd18); mem_rvalid = 1'b0;
        tick(); in_valid = 1'b0;
        chk("rst_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0; mem_rvalid = 1'b1; #1;
        chk("rst_async_we", 64'(rd_we), 64'd0);
        chk("rst_async_waddr", 64'(rd_waddr), 64'd0);
        chk("rst_async_wdata", 64'(rd_wdata), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        tick(); rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_we", 64'(rd_we), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        mem_rvalid = 1'b0;
        tick(); tick();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
